// File: rtl/ram8_pkg.sv
// Shared constants for the two-port RAM arbiter controller: state encoding,
// port identifiers and default RAM geometry.
package ram8_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

endpackage

// File: rtl/ram8_arbiter_ctrl_rr_arb2.sv
// Two-requester grant selection: round-robin against the previous winner,
// or fixed priority to port A. Purely combinational.
module rr_arb2
  import ram8_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic       grant
);

  always_comb begin
    grant = PORT_A;
    if (req == 2'b11) begin
      grant = rr_en ? ~last_grant : PORT_A;
    end else if (req[1]) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/ram8_arbiter_ctrl.sv
// Shares one 8x16 register-file RAM between an instruction-fetch port (A) and a
// data port (B): arbitrate in IDLE, one RAM access cycle, then acknowledge.
module ram8_arbiter_ctrl
  import ram8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_ACK,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic [DATA_W-1:0] B_RDATA,
  output logic              RAM_E,
  output logic              RAM_W,
  output logic              RAM_R,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_D,
  input  logic [DATA_W-1:0] RAM_Q,
  output logic [1:0]        dbg_state
);

  // Requester handshake: a port raises X_REQ with X_WE/X_ADDR/X_WDATA and
  // keeps REQ high until X_ACK, a single-cycle completion pulse. Fields are
  // sampled only in the IDLE cycle that grants the port; REQ still high in
  // the cycle after ACK is a new request using that cycle's fields.

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              ram_e_q, ram_e_d;
  logic              ram_w_q, ram_w_d;
  logic              ram_r_q, ram_r_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;

  logic [1:0]        req;
  logic              arb_grant;

  assign req = {B_REQ, A_REQ};

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .rr_en      (RR_EN),
    .grant      (arb_grant)
  );

  // Strobes and ACKs are flops loaded with the decode of the next state, so
  // they track the state register exactly and reset drops them at once.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_we_d      = op_we_q;
    op_addr_d    = op_addr_q;
    op_wdata_d   = op_wdata_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    ram_e_d      = 1'b0;
    ram_w_d      = 1'b0;
    ram_r_d      = 1'b0;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d    = arb_grant;
          op_we_d    = (arb_grant == PORT_B) ? B_WE    : A_WE;
          op_addr_d  = (arb_grant == PORT_B) ? B_ADDR  : A_ADDR;
          op_wdata_d = (arb_grant == PORT_B) ? B_WDATA : A_WDATA;
          state_d    = ACCESS;
          ram_e_d    = 1'b1;
          ram_w_d    = op_we_d;
          ram_r_d    = ~op_we_d;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!op_we_q) begin
          if (grant_q == PORT_B) begin
            b_rdata_d = RAM_Q;
          end else begin
            a_rdata_d = RAM_Q;
          end
        end
        a_ack_d = (grant_q == PORT_A);
        b_ack_d = (grant_q == PORT_B);
      end
      DONE: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q      <= IDLE;
      grant_q      <= PORT_A;
      last_grant_q <= PORT_B;
      op_we_q      <= 1'b0;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      ram_e_q      <= 1'b0;
      ram_w_q      <= 1'b0;
      ram_r_q      <= 1'b0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_we_q      <= op_we_d;
      op_addr_q    <= op_addr_d;
      op_wdata_q   <= op_wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      ram_e_q      <= ram_e_d;
      ram_w_q      <= ram_w_d;
      ram_r_q      <= ram_r_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
    end
  end

  assign A_ACK     = a_ack_q;
  assign B_ACK     = b_ack_q;
  assign A_RDATA   = a_rdata_q;
  assign B_RDATA   = b_rdata_q;
  assign RAM_E     = ram_e_q;
  assign RAM_W     = ram_w_q;
  assign RAM_R     = ram_r_q;
  assign RAM_ADDR  = op_addr_q;
  assign RAM_D     = op_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram8_arbiter_ctrl.sv
// Bench for ram8_arbiter_ctrl: a round-robin and a fixed-priority instance,
// each with its own RAM macro, checked against a transaction-level model.
module tb_ram8_arbiter_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_;
  always #5 CLK = ~CLK;

  // [instance][port]: instance 0 = round-robin, 1 = fixed priority; port 0 = A, 1 = B
  logic          req_s   [2][2];
  logic          we_s    [2][2];
  logic [AW-1:0] addr_s  [2][2];
  logic [DW-1:0] wdata_s [2][2];
  logic          ack_s   [2][2];
  logic [DW-1:0] rdata_s [2][2];
  logic          ram_e_s    [2];
  logic          ram_w_s    [2];
  logic          ram_r_s    [2];
  logic [AW-1:0] ram_addr_s [2];
  logic [DW-1:0] ram_d_s    [2];
  logic [DW-1:0] ram_q_s    [2];
  logic [1:0]    dbg_s      [2];
  logic [DW-1:0] ram_mem    [2][8];

  int n_checks = 0;
  int n_fail   = 0;

  ram8_arbiter_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) u_rr (
    .CLK(CLK), .RST_(RST_),
    .A_REQ(req_s[0][0]), .A_WE(we_s[0][0]), .A_ADDR(addr_s[0][0]), .A_WDATA(wdata_s[0][0]),
    .A_ACK(ack_s[0][0]), .A_RDATA(rdata_s[0][0]),
    .B_REQ(req_s[0][1]), .B_WE(we_s[0][1]), .B_ADDR(addr_s[0][1]), .B_WDATA(wdata_s[0][1]),
    .B_ACK(ack_s[0][1]), .B_RDATA(rdata_s[0][1]),
    .RAM_E(ram_e_s[0]), .RAM_W(ram_w_s[0]), .RAM_R(ram_r_s[0]),
    .RAM_ADDR(ram_addr_s[0]), .RAM_D(ram_d_s[0]), .RAM_Q(ram_q_s[0]),
    .dbg_state(dbg_s[0])
  );

  ram8_arbiter_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) u_fp (
    .CLK(CLK), .RST_(RST_),
    .A_REQ(req_s[1][0]), .A_WE(we_s[1][0]), .A_ADDR(addr_s[1][0]), .A_WDATA(wdata_s[1][0]),
    .A_ACK(ack_s[1][0]), .A_RDATA(rdata_s[1][0]),
    .B_REQ(req_s[1][1]), .B_WE(we_s[1][1]), .B_ADDR(addr_s[1][1]), .B_WDATA(wdata_s[1][1]),
    .B_ACK(ack_s[1][1]), .B_RDATA(rdata_s[1][1]),
    .RAM_E(ram_e_s[1]), .RAM_W(ram_w_s[1]), .RAM_R(ram_r_s[1]),
    .RAM_ADDR(ram_addr_s[1]), .RAM_D(ram_d_s[1]), .RAM_Q(ram_q_s[1]),
    .dbg_state(dbg_s[1])
  );

  // ---------------- RAM macros ----------------
  assign ram_q_s[0] = (ram_e_s[0] && ram_r_s[0]) ? ram_mem[0][ram_addr_s[0]] : '0;
  assign ram_q_s[1] = (ram_e_s[1] && ram_r_s[1]) ? ram_mem[1][ram_addr_s[1]] : '0;

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_e_s[i] && ram_w_s[i]) ram_mem[i][ram_addr_s[i]] <= ram_d_s[i];
    end
  end

  // ---------------- reference model ----------------
  // One transaction occupies three cycles: grant (IDLE) -> access -> acknowledge.
  int            m_phase [2];
  int            m_win   [2];
  int            m_last  [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wd    [2];
  logic [DW-1:0] m_rd    [2][2];
  logic [DW-1:0] m_mem   [2][8];

  function automatic int pick(input int i);
    if (req_s[i][0] && req_s[i][1]) return (i == 0) ? 1 - m_last[i] : 0;
    return req_s[i][0] ? 0 : 1;
  endfunction

  always @(posedge CLK or negedge RST_) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST_) begin
        m_phase[i]  <= 0;
        m_win[i]    <= 0;
        m_last[i]   <= 1;
        m_rd[i][0]  <= '0;
        m_rd[i][1]  <= '0;
      end else if (m_phase[i] == 0) begin
        if (req_s[i][0] || req_s[i][1]) begin
          m_win[i]   <= pick(i);
          m_we[i]    <= we_s[i][pick(i)];
          m_addr[i]  <= addr_s[i][pick(i)];
          m_wd[i]    <= wdata_s[i][pick(i)];
          m_phase[i] <= 1;
        end
      end else if (m_phase[i] == 1) begin
        if (m_we[i]) m_mem[i][m_addr[i]] <= m_wd[i];
        else m_rd[i][m_win[i]] <= m_mem[i][m_addr[i]];
        m_phase[i] <= 2;
      end else begin
        m_last[i]  <= m_win[i];
        m_phase[i] <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void chk(input int inst, input string nm,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
    end
  endfunction

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST_) begin
        chk(i, "rst ram_e",    32'(ram_e_s[i]),    32'd0);
        chk(i, "rst ram_w",    32'(ram_w_s[i]),    32'd0);
        chk(i, "rst ram_r",    32'(ram_r_s[i]),    32'd0);
        chk(i, "rst ram_addr", 32'(ram_addr_s[i]), 32'd0);
        chk(i, "rst ram_d",    32'(ram_d_s[i]),    32'd0);
        chk(i, "rst a_ack",    32'(ack_s[i][0]),   32'd0);
        chk(i, "rst b_ack",    32'(ack_s[i][1]),   32'd0);
        chk(i, "rst a_rdata",  32'(rdata_s[i][0]), 32'd0);
        chk(i, "rst b_rdata",  32'(rdata_s[i][1]), 32'd0);
        chk(i, "rst state",    32'(dbg_s[i]),      32'd0);
      end else begin
        chk(i, "ram_e",   32'(ram_e_s[i]),    32'(m_phase[i] == 1));
        chk(i, "ram_w",   32'(ram_w_s[i]),    32'(m_phase[i] == 1 && m_we[i]));
        chk(i, "ram_r",   32'(ram_r_s[i]),    32'(m_phase[i] == 1 && !m_we[i]));
        chk(i, "a_ack",   32'(ack_s[i][0]),   32'(m_phase[i] == 2 && m_win[i] == 0));
        chk(i, "b_ack",   32'(ack_s[i][1]),   32'(m_phase[i] == 2 && m_win[i] == 1));
        chk(i, "a_rdata", 32'(rdata_s[i][0]), 32'(m_rd[i][0]));
        chk(i, "b_rdata", 32'(rdata_s[i][1]), 32'(m_rd[i][1]));
        chk(i, "state",   32'(dbg_s[i]),      32'(m_phase[i]));
        if (m_phase[i] == 1) begin
          chk(i, "ram_addr", 32'(ram_addr_s[i]), 32'(m_addr[i]));
          chk(i, "ram_d",    32'(ram_d_s[i]),    32'(m_wd[i]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_both(input int p, input logic rq, input logic we,
                          input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    for (int i = 0; i < 2; i++) begin
      req_s[i][p]   = rq;
      we_s[i][p]    = we;
      addr_s[i][p]  = ad;
      wdata_s[i][p] = wd;
    end
  endtask

  task automatic new_req(input int i, input int p);
    req_s[i][p]   = 1'b1;
    we_s[i][p]    = 1'($urandom_range(1, 0));
    addr_s[i][p]  = AW'($urandom_range(7, 0));
    wdata_s[i][p] = DW'($urandom);
  endtask

  task automatic drive_rand(input int i, input int p);
    logic mine, acking;
    mine   = (m_phase[i] != 0) && (m_win[i] == p);
    acking = (m_phase[i] == 2) && (m_win[i] == p);
    if (acking) begin
      if (req_s[i][p] && $urandom_range(1, 0) == 1) new_req(i, p);
      else if (!req_s[i][p] && $urandom_range(2, 0) == 0) new_req(i, p);
      else req_s[i][p] = 1'b0;
    end else if (mine && req_s[i][p]) begin
      // captured fields may wander; an early REQ drop must not cancel the access
      addr_s[i][p]  = AW'($urandom_range(7, 0));
      wdata_s[i][p] = DW'($urandom);
      if ($urandom_range(7, 0) == 0) req_s[i][p] = 1'b0;
    end else if (!req_s[i][p] && !mine) begin
      if ($urandom_range(2, 0) == 0) new_req(i, p);
      else begin
        we_s[i][p]    = 1'($urandom_range(1, 0));
        addr_s[i][p]  = AW'($urandom_range(7, 0));
        wdata_s[i][p] = DW'($urandom);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req_s[i][p] = 1'b0; we_s[i][p] = 1'b0; addr_s[i][p] = '0; wdata_s[i][p] = '0;
      end
    end
    RST_ = 1'b1;
    #1 RST_ = 1'b0;
    repeat (3) tick();
    RST_ = 1'b1;
    tick();

    // A writes 16'hBEEF to word 5, dropping REQ while in flight
    set_both(0, 1'b1, 1'b1, 3'd5, 16'hBEEF);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t1 ram_e",    32'(ram_e_s[i]),    32'd1);
      chk(i, "t1 ram_w",    32'(ram_w_s[i]),    32'd1);
      chk(i, "t1 ram_addr", 32'(ram_addr_s[i]), 32'd5);
      chk(i, "t1 ram_d",    32'(ram_d_s[i]),    32'hBEEF);
    end
    set_both(0, 1'b0, 1'b1, 3'd5, 16'hBEEF);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t1 a_ack", 32'(ack_s[i][0]), 32'd1);
      chk(i, "t1 b_ack", 32'(ack_s[i][1]), 32'd0);
    end
    tick();

    // B reads word 5
    set_both(1, 1'b1, 1'b0, 3'd5, 16'h0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t2 ram_r",    32'(ram_r_s[i]),    32'd1);
      chk(i, "t2 ram_w",    32'(ram_w_s[i]),    32'd0);
      chk(i, "t2 ram_addr", 32'(ram_addr_s[i]), 32'd5);
    end
    set_both(1, 1'b0, 1'b0, 3'd5, 16'h0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t2 b_ack",   32'(ack_s[i][1]),   32'd1);
      chk(i, "t2 b_rdata", 32'(rdata_s[i][1]), 32'hBEEF);
      chk(i, "t2 a_rdata", 32'(rdata_s[i][0]), 32'd0);
    end
    tick();

    // B writes word 2, then A reads it while moving A_ADDR during the access
    set_both(1, 1'b1, 1'b1, 3'd2, 16'h0A5A);
    tick();
    set_both(1, 1'b0, 1'b1, 3'd2, 16'h0A5A);
    repeat (2) tick();
    set_both(0, 1'b1, 1'b0, 3'd2, 16'h0000);
    tick();
    set_both(0, 1'b1, 1'b0, 3'd6, 16'h0000);
    #1;
    for (int i = 0; i < 2; i++) chk(i, "t6 ram_addr", 32'(ram_addr_s[i]), 32'd2);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t6 a_ack",   32'(ack_s[i][0]),   32'd1);
      chk(i, "t6 a_rdata", 32'(rdata_s[i][0]), 32'h0A5A);
    end
    set_both(0, 1'b0, 1'b0, 3'd6, 16'h0000);
    tick();

    // write 16'h1234 to word 7, then a write of 16'hFFFF cut by reset mid-access
    set_both(0, 1'b1, 1'b1, 3'd7, 16'h1234);
    tick();
    set_both(0, 1'b0, 1'b1, 3'd7, 16'h1234);
    repeat (2) tick();
    set_both(0, 1'b1, 1'b1, 3'd7, 16'hFFFF);
    tick();
    for (int i = 0; i < 2; i++) chk(i, "t5 ram_w pre", 32'(ram_w_s[i]), 32'd1);
    set_both(0, 1'b0, 1'b1, 3'd7, 16'hFFFF);
    #1 RST_ = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "t5 ram_w async", 32'(ram_w_s[i]), 32'd0);
      chk(i, "t5 ram_e async", 32'(ram_e_s[i]), 32'd0);
    end
    tick();
    for (int i = 0; i < 2; i++) chk(i, "t5 a_ack", 32'(ack_s[i][0]), 32'd0);
    tick();
    RST_ = 1'b1;
    tick();
    set_both(0, 1'b1, 1'b0, 3'd7, 16'h0000);
    tick();
    set_both(0, 1'b0, 1'b0, 3'd7, 16'h0000);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "t5 a_ack read",  32'(ack_s[i][0]),   32'd1);
      chk(i, "t5 a_rdata",     32'(rdata_s[i][0]), 32'h1234);
    end
    tick();

    // contention from a fresh reset: both ports read continuously
    RST_ = 1'b0;
    tick();
    RST_ = 1'b1;
    tick();
    set_both(0, 1'b1, 1'b0, 3'd5, 16'h0000);
    set_both(1, 1'b1, 1'b0, 3'd2, 16'h0000);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk(0, "rr a_ack seq", 32'(ack_s[0][0]), 32'(k == 2 || k == 8));
      chk(0, "rr b_ack seq", 32'(ack_s[0][1]), 32'(k == 5 || k == 11 || k == 14));
      chk(1, "fp a_ack seq", 32'(ack_s[1][0]), 32'(k == 2 || k == 5 || k == 8 || k == 11));
      chk(1, "fp b_ack seq", 32'(ack_s[1][1]), 32'(k == 14));
      if (k == 11) set_both(0, 1'b0, 1'b0, 3'd5, 16'h0000);
      if (k == 14) set_both(1, 1'b0, 1'b0, 3'd2, 16'h0000);
    end

    // fill every word with known data before random traffic
    for (int w = 0; w < 8; w++) begin
      set_both(1, 1'b1, 1'b1, AW'(w), DW'($urandom));
      tick();
      set_both(1, 1'b0, 1'b1, AW'(w), 16'h0000);
      repeat (2) tick();
    end

    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) drive_rand(i, p);
      end
    end

    set_both(0, 1'b0, 1'b0, 3'd0, 16'h0000);
    set_both(1, 1'b0, 1'b0, 3'd0, 16'h0000);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
